ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives the PS/2 keyboard serial stream, deserializes 11-bit frames, and decodes Set-2 make/break sequences, including the E0 extended and F0 break prefixes. It drives the held-key bitmap `key[5:0]` and the last-pressed `keycode[7:0]` consumed by the menu/game FSM. It therefore produces exactly the encoding that FSM decodes. It sits between the board's PS/2 pins and the game control path, in the `pclk` domain.

## Interface
- `TIMEOUT`, default 13000: `pclk` cycles without a PS/2 clock falling edge before a partial frame is aborted (200 µs at 65 MHz).
- `pclk` input 1: system/pixel clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `key` output 6: held-key bitmap.
  - bit0 up (E0 75), bit1 down (E0 72), bit2 left (E0 6B), bit3 right (E0 74).
  - bit4 enter (5A or E0 5A), bit5 space (29).
- `keycode` output 8: code byte of the most recent make; 0 when none is held.
- `byte_valid` output 1: one-cycle pulse per accepted byte.
- `rx_byte` output 8: accepted byte; valid while `byte_valid` is high and held until the next byte.
- `frame_err` output 1: one-cycle pulse on a timeout, stop-bit error or parity error.

## Operation
- **Synchronizer:** `ps2_clk` and `ps2_data` each pass through two flip-flops. A falling edge is detected as previous-synchronized=1 and current=0. Data is sampled on the edge cycle.
- **Receiver FSM:**
  - IDLE → DATA when a falling edge samples data=0 (start bit). A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shifts 8 bits, LSB first, with a 3-bit counter.
  - PARITY: samples the parity bit. Odd parity is required: the 8 data bits plus the parity bit contain an odd number of ones.
  - STOP: requires 1. If it is 1, the byte is accepted; if 0, the FSM pulses `frame_err` and drops the byte. It returns to IDLE either way.
  - Watchdog: counts `pclk` cycles since the last edge while not in IDLE. When the count reaches `TIMEOUT`, the FSM returns to IDLE, discards the bits and pulses `frame_err`.
- **Decoder FSM:** states NORM, EXT, BRK, EXT_BRK.
  - E0 in NORM → EXT. F0 in NORM → BRK. F0 in EXT → EXT_BRK.
  - Any other byte: a make (NORM/EXT) or break (BRK/EXT_BRK) of that code with the current extended flag. The FSM then returns to NORM.
  - An E1 byte is ignored and the state is unchanged. E0 in EXT, or E0 in a BRK state, goes to EXT.
- **Make:** sets the mapped `key` bit, if any. Writes `keycode` with the code byte; the E0 prefix is not included.
  - Typematic repeat of a held key leaves `key` unchanged and rewrites `keycode`.
- **Break:** clears the mapped `key` bit. Sets `keycode` to 0 only if it equals the broken code.
  - A break of a key that is not held changes nothing.
- **Mapping:** 75/72/6B/74 map only when extended; unextended forms are keypad digits and do not map. 5A maps with or without E0.
- A `frame_err` resets the decoder FSM to NORM. `key` and `keycode` are unchanged.

## Timing
- **Reset:** all outputs are 0. Receiver is in IDLE, decoder in NORM, and the watchdog and shift register are cleared.
- **Latency:** let E be the `pclk` cycle on which the stop-bit falling edge is detected.
  - `byte_valid`, `rx_byte` and `frame_err` are registered at E+1.
  - `key` and `keycode` update at E+2.
- **Pin to edge:** a pin transition reaches edge detection 2–3 cycles later.
- `byte_valid` and `frame_err` are never high in the same cycle.
- A new start bit on the cycle after the stop edge is accepted. The receiver never needs more than one idle cycle between frames.
- Reset asserted mid-frame aborts it immediately; no pulse is generated.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a parity mismatch drops the byte and pulses `frame_err`.
- Not defined: the parity bit is sampled and ignored. Only stop-bit errors and timeouts raise `frame_err`.

## Structure
- **Shared package `epic_racer_pkg`:**
  - `KEY_UP`/`KEY_DOWN`/`KEY_LEFT`/`KEY_RIGHT`/`KEY_ENTER` one-hot constants: 6'b000001, 000010, 000100, 001000, 010000.
  - New `KEY_SPACE` 6'b100000.
  - Scancode constants: `SC_EXT`=E0, `SC_BREAK`=F0, plus the mapped codes above.
  - These are shared with the menu FSM.
- **Sub-module `ps2_rx`:** synchronizer, receiver FSM and watchdog, producing `rx_byte`/`byte_valid`/`frame_err`. The top level holds the decoder FSM and output registers.

## Test plan
- Frame 5A (parity 1) at a 12 kHz PS/2 clock → `byte_valid` with `rx_byte`=5A, then `key`=6'b010000 and `keycode`=5A. Then F0,5A → `key`=0 and `keycode`=0.
- E0,75 → `key`=000001 and `keycode`=75. Then E0,6B → `key`=000101 and `keycode`=6B. Then E0,F0,75 → `key`=000100 and `keycode` stays 6B.
- Unextended 75 → `key` stays 0 and `keycode`=75. Then F0,75 → `keycode`=0.
- Frame 5A with the parity bit flipped:
  - With `PS2_PARITY_CHECK_EN`: one `frame_err` pulse, no `byte_valid`, `key` unchanged.
  - Without it: `key`=010000.
- Stop ps2_clk after 4 data bits for more than 13000 cycles → `frame_err` pulse and receiver in IDLE. A following valid frame 29 → `key`=100000.
- Assert `rst_n`=0 mid-frame while `key`=000001 → all outputs 0 asynchronously. After release, a new frame decodes correctly.

Source files
------------

// File: rtl/epic_racer_pkg.sv
// ---------------------------------------------------------------------------
// epic_racer_pkg
// Shared constants and helpers for the PS/2 keyboard front end and the
// menu/game FSM that consumes its key bitmap.
//   - KEY_* : one-hot positions inside the held-key bitmap key[5:0]
//   - SC_*  : Set-2 scancode bytes (prefixes and mapped make codes)
//   - rx_state_t / dec_state_t : receiver and decoder FSM encodings
//   - key_map()        : scancode (+ extended flag) -> bitmap bit
//   - odd_parity_ok()  : PS/2 odd-parity check over data + parity bit
// ---------------------------------------------------------------------------
package epic_racer_pkg;

    localparam logic [5:0] KEY_UP    = 6'b000001;
    localparam logic [5:0] KEY_DOWN  = 6'b000010;
    localparam logic [5:0] KEY_LEFT  = 6'b000100;
    localparam logic [5:0] KEY_RIGHT = 6'b001000;
    localparam logic [5:0] KEY_ENTER = 6'b010000;
    localparam logic [5:0] KEY_SPACE = 6'b100000;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_NORM    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    // Arrow codes only map when E0-prefixed; without the prefix they are
    // keypad digits. Enter maps either way.
    function automatic logic [5:0] key_map(input logic [7:0] code, input logic ext);
        logic [5:0] m;
        m = 6'b000000;
        case (code)
            SC_UP:    m = ext ? KEY_UP    : 6'b000000;
            SC_DOWN:  m = ext ? KEY_DOWN  : 6'b000000;
            SC_LEFT:  m = ext ? KEY_LEFT  : 6'b000000;
            SC_RIGHT: m = ext ? KEY_RIGHT : 6'b000000;
            SC_ENTER: m = KEY_ENTER;
            SC_SPACE: m = KEY_SPACE;
            default:  m = 6'b000000;
        endcase
        return m;
    endfunction

    // PS/2 uses odd parity: data bits plus parity bit hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 serial receiver: two-flop synchronizers on clock and data, falling
// edge detection, 11-bit frame FSM (start, 8 data LSB first, parity, stop)
// and an inactivity watchdog.
// Ports:
//   pclk, rst_n         system clock, async active-low reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 pins
//   rx_byte             last accepted byte, held until the next one
//   byte_valid          one-cycle pulse per accepted byte
//   frame_err           one-cycle pulse on timeout / stop / parity error
// Parameter TIMEOUT: pclk cycles without a falling edge before a partial
// frame is aborted.
// Macro PS2_PARITY_CHECK_EN: when defined, a bad parity bit drops the byte
// and raises frame_err; otherwise the parity bit is sampled and ignored.
// ---------------------------------------------------------------------------
module ps2_rx
    import epic_racer_pkg::*;
#(
    parameter int TIMEOUT = 13000
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic            clk_meta_r;
    logic            clk_sync_r;
    logic            clk_prev_r;
    logic            data_meta_r;
    logic            data_sync_r;
    logic            fall_s;

    rx_state_t       state_r;
    rx_state_t       state_s;
    logic [7:0]      shift_r;
    logic [7:0]      shift_s;
    logic [2:0]      bit_cnt_r;
    logic [2:0]      bit_cnt_s;
    logic [WD_W-1:0] wd_r;
    logic [WD_W-1:0] wd_s;
    logic            accept_s;
    logic            err_s;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_r;
    logic            par_s;
`endif

    // Synchronizers; reset to the idle-high bus level so no edge is seen on release.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    assign fall_s = clk_prev_r & ~clk_sync_r;

    // Receiver next-state, shift, watchdog and accept/error decisions.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        accept_s  = 1'b0;
        err_s     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_s     = par_r;
`endif

        case (state_r)
            RX_IDLE: begin
                if (fall_s && !data_sync_r) begin
                    state_s   = RX_DATA;
                    shift_s   = 8'h00;
                    bit_cnt_s = 3'd0;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (fall_s) begin
                    shift_s   = {data_sync_r, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = RX_PARITY;
                    end else begin
                        state_s = RX_DATA;
                    end
                end else begin
                    state_s = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (fall_s) begin
`ifdef PS2_PARITY_CHECK_EN
                    par_s   = data_sync_r;
`endif
                    state_s = RX_STOP;
                end else begin
                    state_s = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (fall_s) begin
                    state_s = RX_IDLE;
                    if (data_sync_r) begin
`ifdef PS2_PARITY_CHECK_EN
                        if (odd_parity_ok(shift_r, par_r)) begin
                            accept_s = 1'b1;
                        end else begin
                            err_s = 1'b1;
                        end
`else
                        accept_s = 1'b1;
`endif
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = RX_STOP;
                end
            end
            default: begin
                state_s = RX_IDLE;
            end
        endcase

        // Watchdog: a stalled partial frame is abandoned and flagged.
        if (state_r == RX_IDLE || fall_s) begin
            wd_s = '0;
        end else if (wd_r >= WD_W'(TIMEOUT)) begin
            wd_s     = '0;
            state_s  = RX_IDLE;
            shift_s  = 8'h00;
            accept_s = 1'b0;
            err_s    = 1'b1;
        end else begin
            wd_s = wd_r + WD_W'(1);
        end
    end

    // Receiver state registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RX_IDLE;
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            wd_r      <= '0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            wd_r      <= wd_s;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    // Captured parity bit, checked on the stop edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            par_r <= 1'b0;
        end else begin
            par_r <= par_s;
        end
    end
`endif

    // Registered byte / error outputs, one cycle after the stop edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= accept_s;
            frame_err  <= err_s;
            if (accept_s) begin
                rx_byte <= shift_r;
            end else begin
                rx_byte <= rx_byte;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// PS/2 keyboard front end: receives Set-2 bytes through ps2_rx and decodes
// make/break sequences (E0 extended, F0 break prefixes, E1 ignored) into a
// held-key bitmap and the last-pressed code byte.
// Ports:
//   pclk, rst_n         system clock, async active-low reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 pins
//   key[5:0]            held keys: up, down, left, right, enter, space
//   keycode[7:0]        code byte of the latest make, 0 once it is released
//   byte_valid, rx_byte accepted byte strobe and value
//   frame_err           one-cycle receive error pulse
// Parameter TIMEOUT: receiver watchdog length in pclk cycles.
// Macro PS2_PARITY_CHECK_EN: enables parity-error rejection in ps2_rx.
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import epic_racer_pkg::*;
#(
    parameter int TIMEOUT = 13000
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [5:0] key,
    output logic [7:0] keycode,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    dec_state_t dec_state_r;
    dec_state_t dec_state_s;
    logic [5:0] key_s;
    logic [7:0] keycode_s;
    logic [5:0] map_s;
    logic       ext_s;
    logic       brk_s;

    ps2_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Decoder next-state and key/keycode updates for each received byte.
    always_comb begin
        dec_state_s = dec_state_r;
        key_s       = key;
        keycode_s   = keycode;
        ext_s       = (dec_state_r == DEC_EXT) || (dec_state_r == DEC_EXT_BRK);
        brk_s       = (dec_state_r == DEC_BRK) || (dec_state_r == DEC_EXT_BRK);
        map_s       = key_map(rx_byte, ext_s);

        if (frame_err) begin
            // A corrupted byte may have been a prefix; forget any pending one.
            dec_state_s = DEC_NORM;
        end else if (byte_valid) begin
            case (rx_byte)
                SC_PAUSE: begin
                    dec_state_s = dec_state_r;
                end
                SC_EXT: begin
                    dec_state_s = DEC_EXT;
                end
                SC_BREAK: begin
                    dec_state_s = ext_s ? DEC_EXT_BRK : DEC_BRK;
                end
                default: begin
                    dec_state_s = DEC_NORM;
                    if (brk_s) begin
                        key_s = key & ~map_s;
                        // Only clear the code if it names the key being released.
                        if (keycode == rx_byte) begin
                            keycode_s = 8'h00;
                        end else begin
                            keycode_s = keycode;
                        end
                    end else begin
                        key_s     = key | map_s;
                        keycode_s = rx_byte;
                    end
                end
            endcase
        end else begin
            dec_state_s = dec_state_r;
        end
    end

    // Decoder state and registered key outputs.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state_r <= DEC_NORM;
            key         <= 6'b000000;
            keycode     <= 8'h00;
        end else begin
            dec_state_r <= dec_state_s;
            key         <= key_s;
            keycode     <= keycode_s;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Drives PS/2 frames into ps2_key_decoder at a scaled bit rate (about 50
// pclk cycles per bit). Expected bytes are queued when each frame is sent
// and compared as byte_valid pulses appear; key/keycode/frame_err results
// are compared inline by each scenario task.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [5:0] key;
    logic [7:0] keycode;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    int         checks   = 0;
    int         errors   = 0;
    int         err_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    ps2_key_decoder dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key        (key),
        .keycode    (keycode),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    always #5 pclk = ~pclk;

    // Scoreboard: compare every accepted byte with the oldest queued expectation.
    always @(negedge pclk) begin
        if (byte_valid && frame_err) begin
            errors++;
            $display("FAIL pulse_overlap byte_valid=1 frame_err=1 required never both");
        end
        if (byte_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got %h required no byte", rx_byte);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_byte !== exp_b) begin
                    errors++;
                    $display("FAIL rx_byte got %h required %h", rx_byte, exp_b);
                end
            end
        end
        if (frame_err) begin
            err_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int setup, input int low, input int high);
        ps2_data = b;
        cyc(setup);
        ps2_clk = 1'b0;
        cyc(low);
        ps2_clk = 1'b1;
        cyc(high);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop,
                              input logic expect_ok, input logic fast_tail);
        logic par;
        par = (~^b) ^ flip_par;
        if (expect_ok) exp_q.push_back(b);
        ps2_bit(1'b0, 1, 20, 20);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 10, 20, 20);
        ps2_bit(par, 10, 20, 20);
        if (fast_tail) ps2_bit(~bad_stop, 10, 1, 1);
        else           ps2_bit(~bad_stop, 10, 20, 20);
        ps2_data = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(4);
        checks++;
        if ({key, keycode, byte_valid, rx_byte, frame_err} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_outputs got key=%b keycode=%h bv=%b rx=%h fe=%b required all 0",
                     key, keycode, byte_valid, rx_byte, frame_err);
        end
        rst_n = 1'b1;
        cyc(5);
    endtask

    task automatic test_enter();
        send_ok(8'h5A);
        cyc(20);
        checks++;
        if (key !== 6'b010000 || keycode !== 8'h5A) begin
            errors++;
            $display("FAIL enter_make got key=%b keycode=%h required 010000 5a", key, keycode);
        end
        send_ok(8'hF0); send_ok(8'h5A);
        cyc(20);
        checks++;
        if (key !== 6'b000000 || keycode !== 8'h00) begin
            errors++;
            $display("FAIL enter_break got key=%b keycode=%h required 000000 00", key, keycode);
        end
    endtask

    task automatic test_extended();
        send_ok(8'hE0); send_ok(8'h75);
        cyc(20);
        checks++;
        if (key !== 6'b000001 || keycode !== 8'h75) begin
            errors++;
            $display("FAIL ext_up got key=%b keycode=%h required 000001 75", key, keycode);
        end
        send_ok(8'hE0); send_ok(8'h6B);
        cyc(20);
        checks++;
        if (key !== 6'b000101 || keycode !== 8'h6B) begin
            errors++;
            $display("FAIL ext_left got key=%b keycode=%h required 000101 6b", key, keycode);
        end
        send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
        cyc(20);
        checks++;
        if (key !== 6'b000100 || keycode !== 8'h6B) begin
            errors++;
            $display("FAIL ext_up_break got key=%b keycode=%h required 000100 6b", key, keycode);
        end
        send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h6B);
        cyc(20);
        checks++;
        if (key !== 6'b000000 || keycode !== 8'h00) begin
            errors++;
            $display("FAIL ext_left_break got key=%b keycode=%h required 000000 00", key, keycode);
        end
    endtask

    task automatic test_unextended();
        send_ok(8'h75);
        cyc(20);
        checks++;
        if (key !== 6'b000000 || keycode !== 8'h75) begin
            errors++;
            $display("FAIL keypad_make got key=%b keycode=%h required 000000 75", key, keycode);
        end
        send_ok(8'hF0); send_ok(8'h75);
        cyc(20);
        checks++;
        if (key !== 6'b000000 || keycode !== 8'h00) begin
            errors++;
            $display("FAIL keypad_break got key=%b keycode=%h required 000000 00", key, keycode);
        end
    endtask

    task automatic test_frame_errors();
        int err0;
        err0 = err_seen;
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(20);
        checks++;
        if (err_seen !== err0 + 1 || key !== 6'b000000 || keycode !== 8'h00) begin
            errors++;
            $display("FAIL parity_err got errs=%0d key=%b keycode=%h required 1 000000 00",
                     err_seen - err0, key, keycode);
        end
`else
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(20);
        checks++;
        if (err_seen !== err0 || key !== 6'b010000 || keycode !== 8'h5A) begin
            errors++;
            $display("FAIL parity_ignored got errs=%0d key=%b keycode=%h required 0 010000 5a",
                     err_seen - err0, key, keycode);
        end
        send_ok(8'hF0); send_ok(8'h5A);
        cyc(20);
`endif
        // Bad stop bit after an E0 prefix: error pulse, prefix forgotten.
        send_ok(8'hE0);
        err0 = err_seen;
        send_frame(8'h75, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(20);
        checks++;
        if (err_seen !== err0 + 1) begin
            errors++;
            $display("FAIL stop_err got errs=%0d required 1", err_seen - err0);
        end
        send_ok(8'h75);
        cyc(20);
        checks++;
        if (key !== 6'b000000 || keycode !== 8'h75) begin
            errors++;
            $display("FAIL err_clears_ext got key=%b keycode=%h required 000000 75", key, keycode);
        end
        send_ok(8'hF0); send_ok(8'h75);
        cyc(20);
    endtask

    task automatic test_timeout();
        int err0;
        err0 = err_seen;
        ps2_bit(1'b0, 1, 20, 20);
        ps2_bit(1'b1, 10, 20, 20);
        ps2_bit(1'b0, 10, 20, 20);
        ps2_bit(1'b1, 10, 20, 20);
        ps2_bit(1'b1, 10, 20, 20);
        ps2_data = 1'b1;
        cyc(12900);
        checks++;
        if (err_seen !== err0) begin
            errors++;
            $display("FAIL timeout_early got errs=%0d required 0", err_seen - err0);
        end
        cyc(200);
        checks++;
        if (err_seen !== err0 + 1) begin
            errors++;
            $display("FAIL timeout_err got errs=%0d required 1", err_seen - err0);
        end
        send_ok(8'h29);
        cyc(20);
        checks++;
        if (key !== 6'b100000 || keycode !== 8'h29) begin
            errors++;
            $display("FAIL after_timeout got key=%b keycode=%h required 100000 29", key, keycode);
        end
        send_ok(8'hF0); send_ok(8'h29);
        cyc(20);
    endtask

    task automatic test_back_to_back();
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h74, 1'b0, 1'b0, 1'b1, 1'b1);
        send_ok(8'h5A);
        cyc(20);
        checks++;
        if (key !== 6'b011000 || keycode !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_make got key=%b keycode=%h required 011000 5a", key, keycode);
        end
        send_frame(8'hE0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h74, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_ok(8'h5A);
        cyc(20);
        checks++;
        if (key !== 6'b000000 || keycode !== 8'h00) begin
            errors++;
            $display("FAIL b2b_break got key=%b keycode=%h required 000000 00", key, keycode);
        end
    endtask

    task automatic test_reset_midframe();
        int err0;
        send_ok(8'hE0); send_ok(8'h75);
        cyc(20);
        checks++;
        if (key !== 6'b000001) begin
            errors++;
            $display("FAIL pre_reset_key got key=%b required 000001", key);
        end
        ps2_bit(1'b0, 1, 20, 20);
        ps2_bit(1'b1, 10, 20, 20);
        ps2_bit(1'b0, 10, 20, 20);
        ps2_data = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({key, keycode, byte_valid, rx_byte, frame_err} !== 24'h000000) begin
            errors++;
            $display("FAIL async_reset got key=%b keycode=%h bv=%b rx=%h fe=%b required all 0",
                     key, keycode, byte_valid, rx_byte, frame_err);
        end
        err0 = err_seen;
        cyc(5);
        rst_n = 1'b1;
        cyc(20);
        checks++;
        if (err_seen !== err0) begin
            errors++;
            $display("FAIL reset_no_pulse got errs=%0d required 0", err_seen - err0);
        end
        send_ok(8'h29);
        cyc(20);
        checks++;
        if (key !== 6'b100000 || keycode !== 8'h29) begin
            errors++;
            $display("FAIL post_reset got key=%b keycode=%h required 100000 29", key, keycode);
        end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_extended();
        test_unextended();
        test_frame_errors();
        test_timeout();
        test_back_to_back();
        test_reset_midframe();
        cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_bytes got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
